// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues single-outstanding imem requests
// and hands fetched instructions to IF/ID through a valid/ready slot with a skid.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_HOLD
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        kill_q, kill_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_instr_q, out_instr_d;

  assign imem_req  = rst_n && (state_q == S_FETCH);
  assign imem_addr = pc_q;
  assign out_valid = out_valid_q;
  assign out_pc    = out_pc_q;
  assign out_instr = out_instr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      req_pc_q     <= '0;
      kill_q       <= 1'b0;
      skid_pc_q    <= '0;
      skid_instr_q <= NOP_INSTR;
      out_valid_q  <= 1'b0;
      out_pc_q     <= '0;
      out_instr_q  <= NOP_INSTR;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      kill_q       <= kill_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      out_valid_q  <= out_valid_d;
      out_pc_q     <= out_pc_d;
      out_instr_q  <= out_instr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    kill_d       = kill_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    out_valid_d  = out_valid_q;
    out_pc_d     = out_pc_q;
    out_instr_d  = out_instr_q;

    // Consumption empties the slot unless a load below refills it.
    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (redirect_valid) begin
      pc_d         = {redirect_pc[31:2], 2'b00};
      out_valid_d  = 1'b0;
      out_instr_d  = NOP_INSTR;
      skid_pc_d    = '0;
      skid_instr_d = NOP_INSTR;
      case (state_q)
        S_FETCH: begin
          // A grant in this cycle used the old pc; its response must be dropped.
          if (imem_gnt) begin
            state_d = S_WAIT;
            kill_d  = 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            state_d = S_FETCH;
            kill_d  = 1'b0;
          end else begin
            kill_d  = 1'b1;
          end
        end
        default: state_d = S_FETCH;
      endcase
    end else begin
      case (state_q)
        S_FETCH: begin
          if (imem_gnt) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + 32'd4;
            state_d  = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (kill_q) begin
              kill_d  = 1'b0;
              state_d = S_FETCH;
            end else if (!out_valid_q || out_ready) begin
              out_pc_d    = req_pc_q;
              out_instr_d = imem_rdata;
              out_valid_d = 1'b1;
              state_d     = S_FETCH;
            end else begin
              skid_pc_d    = req_pc_q;
              skid_instr_d = imem_rdata;
              state_d      = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            out_pc_d    = skid_pc_q;
            out_instr_d = skid_instr_q;
            out_valid_d = 1'b1;
            state_d     = S_FETCH;
          end
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule
